// File: rtl/cla_share_pkg.sv
// Shared types and widths for the cla_16 sharing controller.
package cla_share_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cla_16.sv
// 16-bit two-level carry-lookahead adder exposing group generate/propagate.
module cla_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_in_i,
  output logic [15:0] sum_o,
  output logic        g_out_o,
  output logic        p_out_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [3:0]  cg;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign pg[gi] = &p[B+3:B];
      assign c[B]   = cg[gi];
      assign c[B+1] = g[B] | (p[B] & cg[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & cg[gi]);
    end
  endgenerate

  // Second lookahead level across the four 4-bit groups.
  assign cg[0] = c_in_i;
  assign cg[1] = gg[0] | (pg[0] & c_in_i);
  assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in_i);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & c_in_i);

  assign g_out_o = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                 | (pg[3] & pg[2] & pg[1] & gg[0]);
  assign p_out_o = &pg;
  assign sum_o   = p ^ c;

endmodule

// File: rtl/cla_share_ctrl_rr_arb.sv
// N_REQ-way round-robin arbiter: search begins one past the last grant.
module rr_arb
  import cla_share_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]  last_grant_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  grant_idx_o,
  output logic             grant_any_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      int cand;
      cand = (int'(last_grant_i) + off) % N_REQ;
      if (!grant_any_o && req_valid_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = ID_W'(cand);
        grant_any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cla_share_ctrl.sv
// Shares one cla_16 between N_REQ requesters; 32-bit adds take two passes
// (low half, then high half with the registered carry).
module cla_share_ctrl
  import cla_share_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ-1:0]      req_wide,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WORD_W-1:0]     rsp_sum,
  output logic                  rsp_cout
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   a_q, a_d, b_q, b_d;
  logic                wide_q, wide_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic                carry_q, carry_d;
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic                cout_q, cout_d;

  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [WORD_W-1:0]   sel_a, sel_b;
  logic                sel_wide;

  logic [HALF_W-1:0]   add_a, add_b, add_sum;
  logic                add_cin, add_g, add_p, carry_new;

  rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .grant_any_o  (grant_any)
  );

  // One-hot operand mux driven by the arbiter grant.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_wide = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a    = sel_a | req_a[WORD_W*i +: WORD_W];
        sel_b    = sel_b | req_b[WORD_W*i +: WORD_W];
        sel_wide = sel_wide | req_wide[i];
      end
    end
  end

  assign add_a     = (state_q == HI) ? a_q[WORD_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign add_b     = (state_q == HI) ? b_q[WORD_W-1:HALF_W] : b_q[HALF_W-1:0];
  assign add_cin   = (state_q == HI) & carry_q;
  assign carry_new = add_g | (add_p & add_cin);

  cla_16 u_cla (
    .a_i     (add_a),
    .b_i     (add_b),
    .c_in_i  (add_cin),
    .sum_o   (add_sum),
    .g_out_o (add_g),
    .p_out_o (add_p)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wide_d  = wide_q;
    id_d    = id_q;
    last_d  = last_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          a_d     = sel_a;
          b_d     = sel_b;
          wide_d  = sel_wide;
          id_d    = grant_idx;
          last_d  = grant_idx;
          state_d = LO;
        end
      end
      LO: begin
        sum_d   = {{HALF_W{1'b0}}, add_sum};
        carry_d = carry_new;
        cout_d  = carry_new;
        state_d = wide_q ? HI : DONE;
      end
      HI: begin
        sum_d   = {add_sum, sum_q[HALF_W-1:0]};
        carry_d = carry_new;
        cout_d  = carry_new;
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wide_q  <= 1'b0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wide_q  <= wide_d;
      id_q    <= id_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Grant is masked while reset is held so ready reads zero during reset.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

endmodule

// File: doc/cla_share_ctrl.md
# cla_share_ctrl

Sequencer and round-robin arbiter that shares one `cla_16` carry-lookahead adder between up to four requesters in the ThresholdCutter `square` datapath. Each accepted request is a 16-bit add or a 32-bit add. A 32-bit add runs as two passes through the adder: low half first, then high half, with the carry held in a register between passes. Results return on one shared response channel tagged with the requester ID, using valid/ready backpressure.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept, one-hot or zero.
- `req_wide` in N_REQ: 1 selects a 32-bit add, 0 selects a 16-bit add.
- `req_a` in 32*N_REQ: operand A; requester i owns slice [32i+31:32i].
- `req_b` in 32*N_REQ: operand B, sliced the same way.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out 2: index of the requester that owns the result.
- `rsp_sum` out 32: sum; bits [31:16] are zero for a 16-bit add.
- `rsp_cout` out 1: carry out of the most significant half used.

## Operation
- States: IDLE, LO, HI, DONE.
- **IDLE**
  - `req_ready` is asserted combinationally for the round-robin winner among asserted `req_valid` bits.
  - Search starts at `last_grant+1` modulo N_REQ.
  - On the handshake: latch the winner's a, b, wide and id, set `last_grant` to the winner, go to LO.
- **LO**
  - Adder inputs: a[15:0], b[15:0], c_in=0.
  - Register s_lo and carry, where carry = g_out | (p_out & c_in).
  - If wide, go to HI; otherwise go to DONE.
- **HI**
  - Adder inputs: a[31:16], b[31:16], c_in = registered carry.
  - Register s_hi and carry, then go to DONE.
- **DONE**
  - `rsp_valid`=1; `rsp_sum`, `rsp_id` and `rsp_cout` are held stable.
  - On `rsp_ready`=1, go to IDLE.
  - No new request is accepted in DONE.
- Requesters hold valid and data stable until they see ready. A requester that drops valid before its grant is not served.
- No grant while the block is busy: `req_ready` is 0 in LO, HI and DONE.
- Arithmetic is modulo 2^16 or 2^32; overflow is reported only through `rsp_cout`.
- Reset mid-operation discards the operation in flight. No response is produced for it.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = N_REQ-1 (requester 0 wins first).
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `rsp_cout` = 0.
- Latency, with the accept edge as cycle 0:
  - 16-bit add: `rsp_valid` high at cycle 2.
  - 32-bit add: `rsp_valid` high at cycle 3.
- Minimum issue interval, with no backpressure:
  - 16-bit: 3 cycles.
  - 32-bit: 4 cycles.
- Backpressure: `rsp_valid` and the response data hold for any number of cycles while `rsp_ready`=0.
- If `rsp_ready` is already high when DONE is entered, the handshake completes in that cycle.
- The combinational path per adder pass is one `cla_16` delay and fits in one cycle.

## Structure
- Shared package `cla_share_pkg` holds:
  - the state enum (IDLE/LO/HI/DONE),
  - `HALF_W`=16, `WORD_W`=32, `ID_W`=2.
- The existing `cla_16` is instantiated once. The carry-out is formed locally from its g_out/p_out.
- One sub-module, `rr_arb`: N_REQ-way round-robin grant, taking `req_valid` and `last_grant`, producing a one-hot grant and an encoded index.

## Test plan
- **Reset.** Assert `rst` with random inputs. Required: all outputs match the reset values above, and a request from requester 1 alone is granted after release.
- **16-bit carry.** Req0 sends narrow a=0x0000FFFF, b=0x00000001. Required: `rsp_sum`=0x00000000, `rsp_cout`=1, `rsp_id`=0, `rsp_valid` at cycle 2.
- **32-bit carry.** Req1 sends wide a=0x0000FFFF, b=0x00000001. Required: `rsp_sum`=0x00010000, `rsp_cout`=0, valid at cycle 3. Then wide 0xFFFFFFFF+0x00000001 gives `rsp_sum`=0, `rsp_cout`=1.
- **Arbitration.** Both requesters hold valid continuously. Required: grants alternate 0,1,0,1, the `rsp_id` sequence matches, and no requester starves.
- **Backpressure.** `rsp_ready`=0 for 5 cycles in DONE. Required: response stable throughout, `req_ready` stays 0, and exactly one response is delivered when ready rises.
- **Reset mid-operation.** Assert `rst` in HI of a wide add. Required: no response appears, and the next request completes correctly with req0 priority.
